// File: rtl/fsk_tx_sched.sv
// Transmit byte scheduler for the FSK byte generator: a small byte FIFO feeding a
// start/wait/gap sequencer that issues one start pulse per queued byte.
module fsk_tx_sched #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int GAP_BITS = 2,
    parameter int START_TO = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_dat,
    input  logic          clr_err,
    input  logic          ce_bit,
    input  logic          en_tx,
    output logic          st,
    output logic [7:0]    dat,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          err_to
);

    localparam int TW = $clog2(START_TO + 1);
    localparam int GW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_ON, S_WAIT_OFF, S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      dat_q, dat_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            ovf_q, ovf_d;
    logic            err_to_q, err_to_d;
    logic            pop, wr_accept, fifo_full, to_expire;

    // Storage has no reset so it maps onto plain RAM; only pointers/count define contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_dat;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            dat_q     <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            ovf_q     <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            dat_q     <= dat_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ovf_q     <= ovf_d;
            err_to_q  <= err_to_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        to_expire = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_START;
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_ON;
            end
            S_WAIT_ON: begin
                if (en_tx) begin
                    state_d = S_WAIT_OFF;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    // A byte whose start is never acknowledged is dropped, not retried.
                    if (to_cnt_q == TW'(START_TO - 1)) begin
                        to_expire = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
            end
            S_WAIT_OFF: begin
                if (!en_tx) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (GAP_BITS == 0) begin
                    state_d = S_IDLE;
                end else if (ce_bit) begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                    if ((5'(gap_cnt_q) + 5'd1) == 5'(GAP_BITS)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a pop frees a slot for a write in the same clock.
    always_comb begin
        fifo_full = (count_q == (AW + 1)'(DEPTH));
        pop       = (state_q == S_LOAD);
        wr_accept = wr_en && (!fifo_full || pop);
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d  = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        dat_d     = pop ? mem[rd_ptr_q] : dat_q;
        count_d   = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!wr_accept && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
        ovf_d    = (wr_en && !wr_accept) ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        err_to_d = to_expire ? 1'b1 : (clr_err ? 1'b0 : err_to_q);
    end

    // Output decode, held inactive while reset is asserted.
    always_comb begin
        st    = 1'b0;
        busy  = 1'b0;
        count = '0;
        if (rst_n) begin
            st    = (state_q == S_START);
            busy  = (state_q != S_IDLE);
            count = count_q;
        end
        full   = (count == (AW + 1)'(DEPTH));
        empty  = (count == '0);
        dat    = dat_q;
        ovf    = ovf_q;
        err_to = err_to_q;
    end

endmodule

// File: tb/tb_fsk_tx_sched.sv
// Bench for fsk_tx_sched: a byte queue of expected starts is fed by the stimulus and
// drained by a monitor at every st pulse; a small generator model answers st with en_tx.
module tb_fsk_tx_sched;

    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int GAP_BITS = 2;
    localparam int START_TO = 255;

    logic          clk = 1'b0;
    logic          rst_n, wr_en, clr_err, ce_bit, en_tx;
    logic [7:0]    wr_dat;
    logic          st, busy, full, empty, ovf, err_to;
    logic [7:0]    dat;
    logic [AW:0]   count;

    int            checks = 0;
    int            errors = 0;
    int            st_seen = 0;
    logic [7:0]    exp_q [$];
    bit            gen_echo = 1'b0;
    bit            gen_rand = 1'b0;
    int            gen_dly  = 1;
    int            gen_len  = 10;

    always #5 clk = ~clk;

    fsk_tx_sched #(.DEPTH(DEPTH), .AW(AW), .GAP_BITS(GAP_BITS), .START_TO(START_TO)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_dat(wr_dat), .clr_err(clr_err),
        .ce_bit(ce_bit), .en_tx(en_tx), .st(st), .dat(dat), .busy(busy), .full(full),
        .empty(empty), .count(count), .ovf(ovf), .err_to(err_to)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // Free-running bit strobe, one clock in seven.
    initial begin
        int ce_cnt;
        ce_cnt = 0;
        ce_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ce_bit = (ce_cnt == 0);
            ce_cnt = (ce_cnt == 6) ? 0 : ce_cnt + 1;
        end
    end

    // Generator model: answers a start pulse with an en_tx frame.
    initial begin
        int d, l;
        en_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (st === 1'b1 && gen_echo) begin
                d = gen_rand ? int'($urandom_range(1, 3)) : gen_dly;
                l = gen_rand ? int'($urandom_range(5, 40)) : gen_len;
                repeat (d) @(posedge clk);
                #1 en_tx = 1'b1;
                repeat (l) @(posedge clk);
                #1 en_tx = 1'b0;
            end
        end
    end

    // Monitor: every start pulse must carry the oldest byte still expected.
    initial begin
        forever begin
            @(negedge clk);
            if (st === 1'b1) begin
                st_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_st: got st=1 dat=%0h want no start at %0t", dat, $time);
                end else begin
                    chk("st_dat", dat, exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive_wr(input logic [7:0] b);
        @(posedge clk);
        #1;
        wr_en  = 1'b1;
        wr_dat = b;
    endtask

    task automatic idle_wr();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    task automatic wait_st(input string tag, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (st !== 1'b1 && n < bound);
        chk(tag, st, 1);
    endtask

    task automatic wait_en(input string tag, input logic val, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (en_tx !== val && n < bound);
        chk(tag, en_tx, val);
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy !== 1'b0) && n < bound);
        chk(tag, (exp_q.size() == 0) && (busy === 1'b0), 1);
    endtask

    // Follows one frame to its end; busy must hold through GAP_BITS counted strobes,
    // the strobe in the clock en_tx is seen low not being counted. Returns in IDLE clock.
    task automatic gap_check(input string tag);
        int  strobes;
        bit  done;
        strobes = 0;
        done    = 1'b0;
        wait_en({tag, "_en_hi"}, 1'b1, 1000);
        wait_en({tag, "_en_lo"}, 1'b0, 2000);
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy, (strobes < GAP_BITS) ? 1 : 0);
            if (strobes >= GAP_BITS) done = 1'b1;
            else strobes += int'(ce_bit);
        end
        chk({tag, "_gap_end"}, done, 1);
    endtask

    initial begin
        logic [7:0] b;
        int         st_before;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_dat  = '0;
        clr_err = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st", st, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ovf", ovf, 0);
        chk("idle_err_to", err_to, 0);
        st_before = st_seen;
        repeat (100) @(negedge clk);
        chk("idle_no_st", st_seen - st_before, 0);
        chk("idle_busy", busy, 0);

        // Single byte: st three clocks after the write edge, then gap timing
        gen_echo = 1'b1;
        gen_dly  = 1;
        gen_len  = 500;
        exp_q.push_back(8'hA5);
        drive_wr(8'hA5);
        idle_wr();
        @(negedge clk);
        chk("lat_count1", count, 1);
        chk("lat_st_n0", st, 0);
        @(negedge clk);
        chk("lat_st_n1", st, 0);
        chk("lat_busy_load", busy, 1);
        @(negedge clk);
        chk("lat_st_n2", st, 1);
        chk("lat_dat", dat, 8'hA5);
        gap_check("single");

        // Burst while the generator is busy with a leading frame
        gen_len = 200;
        exp_q.push_back(8'h00);
        drive_wr(8'h00);
        idle_wr();
        wait_en("burst_lead_en", 1'b1, 100);
        gen_len = 30;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            drive_wr(8'(i));
        end
        idle_wr();
        @(negedge clk);
        chk("burst_full", full, 1);
        chk("burst_count", count, DEPTH);

        // Dropped write while full
        drive_wr(8'h99);
        idle_wr();
        @(negedge clk);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, DEPTH);
        pulse_clr();
        @(negedge clk);
        chk("ovf_clr", ovf, 0);

        // Write landing in the LOAD clock while full is accepted
        gap_check("lead");
        exp_q.push_back(8'h09);
        drive_wr(8'h09);
        @(negedge clk);
        chk("load_busy", busy, 1);
        idle_wr();
        @(negedge clk);
        chk("load_wr_count", count, DEPTH);
        chk("load_wr_full", full, 1);
        chk("load_wr_ovf", ovf, 0);
        drain("burst_drain", 5000);

        // Randomized traffic, never writing beyond what the FIFO can hold
        gen_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int n;
            n = 0;
            repeat ($urandom_range(0, 12)) @(posedge clk);
            while (exp_q.size() >= DEPTH && n < 3000) begin
                @(posedge clk);
                n++;
            end
            chk("rand_room", exp_q.size() < DEPTH, 1);
            b = 8'($urandom);
            exp_q.push_back(b);
            drive_wr(b);
            idle_wr();
        end
        drain("rand_drain", 8000);
        chk("rand_ovf", ovf, 0);
        chk("rand_err_to", err_to, 0);
        gen_rand = 1'b0;

        // Timeout: generator never answers
        gen_echo = 1'b0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C);
        drive_wr(8'h5A);
        drive_wr(8'h3C);
        idle_wr();
        wait_st("to_st", 100);
        repeat (START_TO) @(negedge clk);
        chk("to_before", err_to, 0);
        @(negedge clk);
        chk("to_set", err_to, 1);
        chk("to_busy_gap", busy, 1);
        drain("to_drain", 2000);
        chk("to_sticky", err_to, 1);
        pulse_clr();
        @(negedge clk);
        chk("to_clr", err_to, 0);

        // Reset while a frame is in progress
        gen_echo = 1'b1;
        gen_len  = 100;
        gen_dly  = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'hC0 + 8'(i));
            drive_wr(8'hC0 + 8'(i));
        end
        idle_wr();
        wait_en("mid_en", 1'b1, 100);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_st", st, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after_empty", empty, 1);
        chk("mid_after_busy", busy, 0);
        st_before = st_seen;
        repeat (100) @(negedge clk);
        chk("mid_no_st", st_seen - st_before, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
